// File: rtl/core_alu_seq.sv
// Sequencer for the core ALU source mux: steps single-pass ops, AMO read-modify-write
// and CSR read-modify-write through their phases and handshakes with the data-memory port.
module core_alu_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [2:0] cmd_op1_sel,
  input  logic [2:0] cmd_op2_sel,
  output logic [2:0] op1_sel,
  output logic [2:0] op2_sel,
  output logic       alu_en,
  output logic       save_reg2,
  output logic       mem_req_valid,
  input  logic       mem_req_ready,
  output logic       mem_req_write,
  input  logic       mem_rsp_valid,
  output logic       csr_we,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       done_err,
  output logic       busy
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] KIND_SINGLE = 2'd0;
  localparam logic [1:0] KIND_AMO    = 2'd1;
  localparam logic [1:0] KIND_CSR    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ADDR,
    S_RD_WAIT,
    S_MODIFY,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    kind_q;
  logic [2:0]    op1_q;
  logic [2:0]    op2_q;
  logic          err_q;
  logic          err_n;
  logic [CW-1:0] tcnt;
  logic          accept;
  logic          waiting;
  logic          expired;

  assign accept  = cmd_valid && (state == S_IDLE);
  assign waiting = (state == S_ADDR) || (state == S_RD_WAIT) ||
                   (state == S_WR_REQ) || (state == S_WR_WAIT);
  // A zero timeout disables expiry; the counter saturates rather than wrapping.
  assign expired = (TIMEOUT_CYCLES != 0) && (int'(tcnt) == TIMEOUT_CYCLES - 1);

  // save_reg2 is the only output taken straight from the inputs.
  assign save_reg2 = accept && (cmd_kind == KIND_AMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      err_q  <= 1'b0;
      kind_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      tcnt   <= '0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (accept) begin
        kind_q <= cmd_kind;
        op1_q  <= cmd_op1_sel;
        op2_q  <= cmd_op2_sel;
      end
      if (state_n != state) begin
        tcnt <= '0;
      end else if (waiting && (tcnt != {CW{1'b1}})) begin
        tcnt <= tcnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_kind)
            KIND_SINGLE, KIND_CSR: state_n = S_EXEC;
            KIND_AMO:              state_n = S_ADDR;
            default: begin
              state_n = S_DONE;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      S_EXEC:   state_n = S_DONE;
      S_ADDR: begin
        if (mem_req_ready) begin
          state_n = S_RD_WAIT;
        end else if (expired) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (mem_rsp_valid) begin
          state_n = S_MODIFY;
        end else if (expired) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_MODIFY: state_n = S_WR_REQ;
      S_WR_REQ: begin
        if (mem_req_ready) begin
          state_n = S_WR_WAIT;
        end else if (expired) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (mem_rsp_valid) begin
          state_n = S_DONE;
        end else if (expired) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_n = S_IDLE;
          err_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Every output below depends only on the registered state and latched fields.
  always_comb begin
    cmd_ready     = 1'b0;
    op1_sel       = 3'd0;
    op2_sel       = 3'd0;
    alu_en        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    csr_we        = 1'b0;
    done_valid    = 1'b0;
    done_err      = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        alu_en = 1'b1;
        if (kind_q == KIND_CSR) begin
          op2_sel = 3'd3;
          csr_we  = 1'b1;
        end else begin
          op1_sel = op1_q;
          op2_sel = op2_q;
        end
      end
      S_ADDR: begin
        op2_sel       = 3'd2;
        alu_en        = 1'b1;
        mem_req_valid = 1'b1;
      end
      S_MODIFY: begin
        op1_sel = 3'd1;
        op2_sel = 3'd1;
        alu_en  = 1'b1;
      end
      S_WR_REQ: begin
        op2_sel       = 3'd2;
        alu_en        = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
